// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan
//  Purpose  : Binary value -> BCD (sequential shift-add-3) -> time-multiplexed
//             common-anode seven-segment scan with leading-zero blanking,
//             overflow dashes and a display enable.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 8,
    parameter int VALUE_W     = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  disp_en,
    output logic                  busy,
    output logic                  done,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W);
    localparam int RC_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

    // Smallest value that no longer fits in NUM_DIGITS decimal digits
    localparam logic [31:0] OVF_LIMIT = pow10(NUM_DIGITS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    logic [1:0]            state_q,  state_d;
    logic [VALUE_W-1:0]    shift_q,  shift_d;
    logic [BCD_W-1:0]      bcd_q,    bcd_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  ovf_q,    ovf_d;
    logic [BCD_W-1:0]      digits_q, digits_d;
    logic                  dash_q,   dash_d;
    logic                  done_q,   done_d;
    logic [RC_W-1:0]       rcnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;

    logic [BCD_W-1:0]      w_bcd_adj;
    logic                  w_tail_zero;
    logic [3:0]            w_sel_digit;
    logic                  w_sel_blank;
    logic [6:0]            w_seg_next;
    logic [NUM_DIGITS-1:0] w_an_next;

    // Add-3 correction on every nibble that would reach 10 or more after the shift
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                          bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
        end
    endgenerate

    // Conversion FSM next-state: capture, VALUE_W shift steps, one commit cycle
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        digits_d = digits_q;
        dash_d   = dash_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_CONV;
                    shift_d = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (32'(value) >= OVF_LIMIT);
                end
            end
            S_CONV: begin
                // Carry out of the top nibble is dropped; overflow is flagged separately
                bcd_d   = BCD_W'({w_bcd_adj, shift_q[VALUE_W-1]});
                shift_d = shift_q << 1;
                if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                digits_d = bcd_q;
                dash_d   = ovf_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Conversion and display-digit state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            digits_q <= '0;
            dash_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            digits_q <= digits_d;
            dash_q   <= dash_d;
            done_q   <= done_d;
        end
    end

    // Refresh prescaler and digit index; independent of conversions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcnt_q <= '0;
            idx_q  <= '0;
        end else if (rcnt_q == RC_W'(REFRESH_DIV - 1)) begin
            rcnt_q <= '0;
            idx_q  <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            rcnt_q <= rcnt_q + RC_W'(1);
        end
    end

    // Select the scanned digit and decide blanking (all digits from it upward are zero)
    always_comb begin
        w_tail_zero = 1'b1;
        w_sel_digit = 4'd0;
        w_sel_blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_tail_zero = w_tail_zero & (digits_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                w_sel_digit = digits_q[4*i +: 4];
                w_sel_blank = (i != 0) && blank_lz && w_tail_zero;
            end
        end
        w_seg_next = dash_q ? SEG_DASH : (w_sel_blank ? SEG_BLANK : decode(w_sel_digit));
        w_an_next  = disp_en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    end

    // Registered segment and anode drivers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            seg_q <= w_seg_next;
            an_q  <= w_an_next;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scan
//  Purpose  : Self-checking bench for seven_seg_scan (4 digits, 14-bit value,
//             4-cycle refresh slot) against a decimal-arithmetic display model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

    localparam int N = 4;
    localparam int W = 14;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] value;
    logic         load;
    logic         blank_lz;
    logic         disp_en;
    logic         busy;
    logic         done;
    logic [6:0]   seg;
    logic [N-1:0] an;

    int tests    = 0;
    int fails    = 0;
    int k        = 0;   // rising edges since reset release
    int done_cnt = 0;

    // Display model state: value currently shown and the control inputs
    int m_val = 0;
    bit m_blz = 1'b1;
    bit m_en  = 1'b1;

    seven_seg_scan #(
        .NUM_DIGITS (N),
        .VALUE_W    (W),
        .REFRESH_DIV(D)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (value),
        .load    (load),
        .blank_lz(blank_lz),
        .disp_en (disp_en),
        .busy    (busy),
        .done    (done),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) k <= 0;
        else          k <= k + 1;
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Segment pattern expected at digit position pos for displayed value v
    function automatic logic [6:0] exp_seg(input int v, input int pos, input bit blz);
        if (v >= pow10(N))                       return 7'b0111111;
        if (pos > 0 && blz && v < pow10(pos))    return 7'b1111111;
        return seg_code((v / pow10(pos)) % 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    // Compare seg/an against the model for the slot implied by the edge count
    task automatic check_disp();
        int idx;
        logic [N-1:0] ean;
        idx = ((k - 1) / D) % N;
        ean = m_en ? N'(~(32'd1 << idx)) : {N{1'b1}};
        chk("an", 32'(an), 32'(ean));
        chk("seg", 32'(seg), 32'(exp_seg(m_val, idx, m_blz)));
    endtask

    task automatic check_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            check_disp();
        end
    endtask

    // Load a value and check busy/done timing, held display and the new display
    task automatic do_load(input int v);
        int d0;
        d0    = done_cnt;
        value = W'(v);
        load  = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check_disp();
        chk("busy_E0", 32'(busy), 32'd1);
        chk("done_E0", 32'(done), 32'd0);
        for (int c = 1; c <= W + 1; c++) begin
            @(posedge clk); #1;
            check_disp();
            if (c <= W) begin
                chk("busy_conv", 32'(busy), 32'd1);
                chk("done_conv", 32'(done), 32'd0);
            end else begin
                chk("busy_commit", 32'(busy), 32'd0);
                chk("done_commit", 32'(done), 32'd1);
            end
        end
        m_val = v;
        @(posedge clk); #1;
        check_disp();
        chk("done_after", 32'(done), 32'd0);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int d0;
        int v;
        reset_n  = 1'b0;
        value    = '0;
        load     = 1'b0;
        blank_lz = 1'b1;
        disp_en  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Scan after release: two full frames of zero with blanking
        reset_n = 1'b1;
        check_cycles(2 * N * D);

        // Directed values
        do_load(1234);  check_cycles(N * D);
        do_load(9999);  check_cycles(N * D);
        do_load(10000); check_cycles(N * D);
        do_load(7);     check_cycles(N * D);
        blank_lz = 1'b0; m_blz = 1'b0;
        check_cycles(N * D);
        blank_lz = 1'b1; m_blz = 1'b1;
        check_cycles(N * D);

        // Display disable keeps scanning with anodes off
        disp_en = 1'b0; m_en = 1'b0;
        check_cycles(N * D);
        disp_en = 1'b1; m_en = 1'b1;
        check_cycles(N * D);

        // Randomized values and controls
        for (int r = 0; r < 10; r++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99))
                                            : int'($urandom_range(0, 16383));
            blank_lz = 1'($urandom_range(0, 1)); m_blz = blank_lz;
            do_load(v);
            check_cycles(N * D);
        end
        blank_lz = 1'b1; m_blz = 1'b1;

        // Second load at cycle 5 of a conversion is ignored
        do_load(56);
        d0    = done_cnt;
        value = W'(1234);
        load  = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check_disp();
        for (int c = 1; c <= W + 1; c++) begin
            if (c == 5) begin
                value = W'(42);
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(posedge clk); #1;
            check_disp();
            if (c <= W) chk("busy_hold", 32'(busy), 32'd1);
        end
        load  = 1'b0;
        m_val = 1234;
        check_cycles(2 * N * D);
        chk("ignored_load_done", 32'(done_cnt - d0), 32'd1);
        chk("ignored_load_busy", 32'(busy), 32'd0);

        // Reset in the middle of a conversion
        do_load(9999);
        d0    = done_cnt;
        value = W'(1234);
        load  = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            check_disp();
        end
        reset_n = 1'b0;
        #1;
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_val   = 0;
        check_cycles(2 * N * D);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_rst_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
